// File: rtl/softmax_pkg.sv
// Shared widths and length-mode encodings for the softmax-approx datapath.
package softmax_pkg;

    localparam int LANES = 64;
    localparam int DW    = 16;

    localparam logic [3:0] MODE_SEG16   = 4'd0;
    localparam logic [3:0] MODE_SEG32   = 4'd1;
    localparam logic [3:0] MODE_ROW64   = 4'd2;
    localparam logic [3:0] MODE_GRP_MIN = 4'd3;
    localparam logic [3:0] MODE_GRP_MAX = 4'd13;

    function automatic logic is_reserved_mode(input logic [3:0] mode);
        return (mode > MODE_GRP_MAX);
    endfunction

endpackage

// File: rtl/sat_sub_lane.sv
// One lane of the subtract stage: x - max in DW+1 bits, clamped back to DW bits.
module sat_sub_lane #(
    parameter int DW = 16
) (
    input  logic [DW-1:0] i_x,
    input  logic [DW-1:0] i_max,
    output logic [DW-1:0] o_diff,
    output logic          o_sat
);

    logic [DW:0] diff;

    always_comb begin
        diff   = {i_x[DW-1], i_x} - {i_max[DW-1], i_max};
        // Overflow into DW bits shows as the top two bits disagreeing.
        o_sat  = diff[DW] ^ diff[DW-1];
        o_diff = diff[DW-1:0];
        if (o_sat) begin
            o_diff = diff[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/max_subtract.sv
// Two-stage max-subtract: S1 picks each lane's reference max by length mode,
// S2 forms the saturated difference. Both stages advance only on i_en.
module max_subtract
    import softmax_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic [3:0]            i_length_mode,
    input  logic [LANES*DW-1:0]   i_in_flat,
    input  logic [DW-1:0]         i_global_max,
    input  logic [DW-1:0]         i_max64_0,
    input  logic [DW-1:0]         i_max32_0,
    input  logic [DW-1:0]         i_max32_1,
    input  logic [DW-1:0]         i_max16_0,
    input  logic [DW-1:0]         i_max16_1,
    input  logic [DW-1:0]         i_max16_2,
    input  logic [DW-1:0]         i_max16_3,
    output logic                  o_valid,
    output logic [3:0]            o_length_mode,
    output logic [LANES*DW-1:0]   o_diff_flat,
    output logic                  o_sat_any,
    output logic                  o_mode_err
);

    localparam int W = LANES * DW;

    logic [4*DW-1:0] max16_flat;
    logic [2*DW-1:0] max32_flat;
    logic [W-1:0]    sel_max;
    logic [W-1:0]    lane_diff;
    logic [LANES-1:0] lane_sat;

    logic [W-1:0] s1_x_d, s1_x_q;
    logic [W-1:0] s1_max_d, s1_max_q;
    logic         s1_valid_d, s1_valid_q;
    logic [3:0]   s1_mode_d, s1_mode_q;
    logic         s1_err_d, s1_err_q;

    logic [W-1:0] s2_diff_d, s2_diff_q;
    logic         s2_valid_d, s2_valid_q;
    logic [3:0]   s2_mode_d, s2_mode_q;
    logic         s2_sat_d, s2_sat_q;
    logic         s2_err_d, s2_err_q;

    assign max16_flat = {i_max16_3, i_max16_2, i_max16_1, i_max16_0};
    assign max32_flat = {i_max32_1, i_max32_0};

    always_comb begin
        sel_max = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i_length_mode == MODE_SEG16) begin
                sel_max[i*DW +: DW] = max16_flat[(i/16)*DW +: DW];
            end else if (i_length_mode == MODE_SEG32) begin
                sel_max[i*DW +: DW] = max32_flat[(i/32)*DW +: DW];
            end else if (i_length_mode == MODE_ROW64 || is_reserved_mode(i_length_mode)) begin
                sel_max[i*DW +: DW] = i_max64_0;
            end else begin
                sel_max[i*DW +: DW] = i_global_max;
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sat_sub_lane #(.DW(DW)) u_lane (
            .i_x    (s1_x_q[g*DW +: DW]),
            .i_max  (s1_max_q[g*DW +: DW]),
            .o_diff (lane_diff[g*DW +: DW]),
            .o_sat  (lane_sat[g])
        );
    end

    always_comb begin
        s1_x_d     = s1_x_q;
        s1_max_d   = s1_max_q;
        s1_valid_d = s1_valid_q;
        s1_mode_d  = s1_mode_q;
        s1_err_d   = s1_err_q;
        s2_diff_d  = s2_diff_q;
        s2_valid_d = s2_valid_q;
        s2_mode_d  = s2_mode_q;
        s2_sat_d   = s2_sat_q;
        s2_err_d   = s2_err_q;
        if (i_en) begin
            s1_x_d     = i_in_flat;
            s1_max_d   = sel_max;
            s1_valid_d = i_valid;
            s1_mode_d  = i_length_mode;
            s1_err_d   = i_valid && is_reserved_mode(i_length_mode);
            s2_diff_d  = lane_diff;
            s2_valid_d = s1_valid_q;
            s2_mode_d  = s1_mode_q;
            // Flags only mean something for a valid row.
            s2_sat_d   = s1_valid_q && (|lane_sat);
            s2_err_d   = s1_valid_q && s1_err_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            s1_x_q     <= '0;
            s1_max_q   <= '0;
            s1_valid_q <= 1'b0;
            s1_mode_q  <= '0;
            s1_err_q   <= 1'b0;
            s2_diff_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_mode_q  <= '0;
            s2_sat_q   <= 1'b0;
            s2_err_q   <= 1'b0;
        end else begin
            s1_x_q     <= s1_x_d;
            s1_max_q   <= s1_max_d;
            s1_valid_q <= s1_valid_d;
            s1_mode_q  <= s1_mode_d;
            s1_err_q   <= s1_err_d;
            s2_diff_q  <= s2_diff_d;
            s2_valid_q <= s2_valid_d;
            s2_mode_q  <= s2_mode_d;
            s2_sat_q   <= s2_sat_d;
            s2_err_q   <= s2_err_d;
        end
    end

    assign o_valid       = s2_valid_q;
    assign o_length_mode = s2_mode_q;
    assign o_diff_flat   = s2_diff_q;
    assign o_sat_any     = s2_sat_q;
    assign o_mode_err    = s2_err_q;

endmodule

// File: tb/tb_max_subtract.sv
// Bench for max_subtract: hand-derived vector table, scoreboard queue checked
// at the output, plus reset, stall and async-reset sequences.
module tb_max_subtract;
    import softmax_pkg::*;

    localparam int W  = LANES * DW;
    localparam int NV = 9;

    typedef struct {
        logic [3:0]      mode;
        logic [W-1:0]    x;
        logic [DW-1:0]   gmax;
        logic [DW-1:0]   m64;
        logic [2*DW-1:0] m32;
        logic [4*DW-1:0] m16;
        logic [W-1:0]    exp_d;
        logic            exp_sat;
        logic            exp_err;
    } vec_t;

    typedef struct {
        logic [3:0]   mode;
        logic [W-1:0] d;
        logic         sat;
        logic         err;
        int           id;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            en;
    logic            i_valid;
    logic [3:0]      i_mode;
    logic [W-1:0]    i_x;
    logic [DW-1:0]   i_gmax;
    logic [DW-1:0]   i_m64;
    logic [2*DW-1:0] i_m32;
    logic [4*DW-1:0] i_m16;
    logic            o_valid;
    logic [3:0]      o_mode;
    logic [W-1:0]    o_diff;
    logic            o_sat;
    logic            o_err;

    vec_t vecs[NV];
    exp_t sb[$];
    exp_t cur_exp;
    logic adv = 1'b0;
    logic mon_on = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    max_subtract dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_en          (en),
        .i_valid       (i_valid),
        .i_length_mode (i_mode),
        .i_in_flat     (i_x),
        .i_global_max  (i_gmax),
        .i_max64_0     (i_m64),
        .i_max32_0     (i_m32[15:0]),
        .i_max32_1     (i_m32[31:16]),
        .i_max16_0     (i_m16[15:0]),
        .i_max16_1     (i_m16[31:16]),
        .i_max16_2     (i_m16[47:32]),
        .i_max16_3     (i_m16[63:48]),
        .o_valid       (o_valid),
        .o_length_mode (o_mode),
        .o_diff_flat   (o_diff),
        .o_sat_any     (o_sat),
        .o_mode_err    (o_err)
    );

    function automatic logic [W-1:0] fill(logic [W-1:0] f, int lo, int hi, logic [DW-1:0] v);
        for (int i = lo; i <= hi; i++) f[i*DW +: DW] = v;
        return f;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_row(string name, logic [W-1:0] act, logic [W-1:0] exp);
        int l;
        checks++;
        if (act !== exp) begin
            errors++;
            l = 0;
            for (int i = LANES - 1; i >= 0; i--)
                if (act[i*DW +: DW] !== exp[i*DW +: DW]) l = i;
            $display("FAIL %s lane %0d: got %0d expected %0d", name, l,
                     $signed(act[l*DW +: DW]), $signed(exp[l*DW +: DW]));
        end
    endtask

    task automatic build_vecs();
        vec_t v;
        // 0: mode 0, segment 0 = 100 vs 300, other segments equal their max
        v.mode = 4'd0; v.gmax = 16'd3333; v.m64 = 16'd2222; v.m32 = {2{16'd1234}};
        v.m16 = {16'h8000, 16'd7000, 16'hFFCE, 16'd300};
        v.x = fill('0, 0, 15, 16'd100); v.x = fill(v.x, 16, 31, 16'hFFCE);
        v.x = fill(v.x, 32, 47, 16'd7000); v.x = fill(v.x, 48, 63, 16'h8000);
        v.exp_d = fill('0, 0, 15, 16'hFF38); v.exp_sat = 0; v.exp_err = 0;
        vecs[0] = v;
        // 1: mode 1, lane 40 = -32768 vs 32767 saturates low
        v.mode = 4'd1; v.gmax = 16'd200; v.m64 = 16'd100; v.m32 = {16'h7FFF, 16'd5};
        v.m16 = {4{16'd9}};
        v.x = fill('0, 0, 31, 16'd5); v.x = fill(v.x, 32, 63, 16'h7FFF);
        v.x = fill(v.x, 40, 40, 16'h8000);
        v.exp_d = fill('0, 40, 40, 16'h8000); v.exp_sat = 1; v.exp_err = 0;
        vecs[1] = v;
        // 2: mode 7, group max selected
        v.mode = 4'd7; v.gmax = 16'd1200; v.m64 = '0; v.m32 = '0; v.m16 = '0;
        v.x = fill('0, 0, 63, 16'd1000);
        v.exp_d = fill('0, 0, 63, 16'hFF38); v.exp_sat = 0; v.exp_err = 0;
        vecs[2] = v;
        // 3: mode 2, ramp minus row max (some results positive)
        v.mode = 4'd2; v.gmax = 16'd4; v.m64 = 16'd3000; v.m32 = {2{16'd2}}; v.m16 = {4{16'd1}};
        for (int i = 0; i < LANES; i++) begin
            v.x[i*DW +: DW]     = 16'(i * 100);
            v.exp_d[i*DW +: DW] = 16'(i * 100 - 3000);
        end
        v.exp_sat = 0; v.exp_err = 0;
        vecs[3] = v;
        // 4: mode 3 (lowest group mode), lane 5 saturates high
        v.mode = 4'd3; v.gmax = 16'hFF9C; v.m64 = 16'd50; v.m32 = '0; v.m16 = '0;
        v.x = fill('0, 5, 5, 16'h7FFF);
        v.exp_d = fill('0, 0, 63, 16'd100); v.exp_d = fill(v.exp_d, 5, 5, 16'h7FFF);
        v.exp_sat = 1; v.exp_err = 0;
        vecs[4] = v;
        // 5: mode 13 (highest group mode)
        v.mode = 4'd13; v.gmax = 16'hFFFB; v.m64 = 16'd7; v.m32 = '0; v.m16 = '0;
        v.x = fill('0, 0, 63, 16'hFFFB);
        v.exp_d = '0; v.exp_sat = 0; v.exp_err = 0;
        vecs[5] = v;
        // 6: mode 15, reserved: max64 used, error flagged
        v.mode = 4'd15; v.gmax = 16'd99; v.m64 = 16'd4; v.m32 = {2{16'd2}}; v.m16 = {4{16'd1}};
        v.x = fill('0, 0, 63, 16'd10);
        v.exp_d = fill('0, 0, 63, 16'd6); v.exp_sat = 0; v.exp_err = 1;
        vecs[6] = v;
        // 7: mode 14, reserved and saturating
        v.mode = 4'd14; v.gmax = 16'h8000; v.m64 = 16'd1; v.m32 = '0; v.m16 = '0;
        v.x = fill('0, 0, 63, 16'h8000);
        v.exp_d = fill('0, 0, 63, 16'h8000); v.exp_sat = 1; v.exp_err = 1;
        vecs[7] = v;
        // 8: mode 0, distinct per-segment maxima, segment 3 saturates high
        v.mode = 4'd0; v.gmax = '0; v.m64 = '0; v.m32 = {2{16'h8000}};
        v.m16 = {16'h8000, 16'd3, 16'd2, 16'd1};
        v.x = fill('0, 48, 63, 16'h7FFF);
        v.exp_d = fill('0, 0, 15, 16'hFFFF); v.exp_d = fill(v.exp_d, 16, 31, 16'hFFFE);
        v.exp_d = fill(v.exp_d, 32, 47, 16'hFFFD); v.exp_d = fill(v.exp_d, 48, 63, 16'h7FFF);
        v.exp_sat = 1; v.exp_err = 0;
        vecs[8] = v;
    endtask

    task automatic apply(int id, logic valid);
        i_valid = valid;
        i_mode  = vecs[id].mode;
        i_x     = vecs[id].x;
        i_gmax  = vecs[id].gmax;
        i_m64   = vecs[id].m64;
        i_m32   = vecs[id].m32;
        i_m16   = vecs[id].m16;
        cur_exp.mode = vecs[id].mode;
        cur_exp.d    = vecs[id].exp_d;
        cur_exp.sat  = vecs[id].exp_sat;
        cur_exp.err  = vecs[id].exp_err;
        cur_exp.id   = id;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        adv <= rst_n && en;
        if (rst_n && en && i_valid) sb.push_back(cur_exp);
    end

    always @(negedge clk) begin
        exp_t e;
        if (mon_on && adv) begin
            if (o_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_row: got mode %0d expected no row", o_mode);
                end else begin
                    e = sb.pop_front();
                    chk_row($sformatf("diff_v%0d", e.id), o_diff, e.d);
                    chk($sformatf("mode_v%0d", e.id), 32'(o_mode), 32'(e.mode));
                    chk($sformatf("sat_v%0d", e.id), 32'(o_sat), 32'(e.sat));
                    chk($sformatf("err_v%0d", e.id), 32'(o_err), 32'(e.err));
                end
            end else begin
                chk("invalid_row_flags", 32'({o_sat, o_err}), 32'd0);
            end
        end
    end

    initial begin
        build_vecs();
        rst_n = 1'b0;
        en    = 1'b1;
        apply(0, 1'b1);
        mon_on = 1'b1;

        // reset held with valid rows driven
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("rst_valid", 32'(o_valid), 32'd0);
            chk_row("rst_diff", o_diff, '0);
        end
        #2 rst_n = 1'b1;
        step();
        apply(0, 1'b0);
        @(negedge clk);
        chk("latency_edge1_valid", 32'(o_valid), 32'd0);
        @(negedge clk);
        chk("latency_edge2_valid", 32'(o_valid), 32'd1);

        // table: back-to-back rows, then invalid rows carrying flagged data
        for (int k = 0; k < NV; k++) begin
            step();
            apply(k, 1'b1);
        end
        step(); apply(7, 1'b0);
        step(); apply(3, 1'b0);
        step(); apply(8, 1'b1);
        step(); apply(0, 1'b0);
        repeat (4) step();
        chk("table_drained", 32'(sb.size()), 32'd0);

        // stall with three rows in flight
        apply(0, 1'b1);
        step(); apply(1, 1'b1);
        step(); apply(6, 1'b1);
        en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("stall_valid", 32'(o_valid), 32'd1);
            chk("stall_mode", 32'(o_mode), 32'd0);
            chk_row("stall_diff", o_diff, vecs[0].exp_d);
        end
        step();
        en = 1'b1;
        step(); apply(0, 1'b0);
        repeat (4) step();
        chk("stall_drained", 32'(sb.size()), 32'd0);

        // async reset between edges with rows in flight
        apply(2, 1'b1);
        step(); apply(4, 1'b1);
        step(); apply(0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(o_valid), 32'd0);
        chk_row("async_rst_diff", o_diff, '0);
        chk("async_rst_flags", 32'({o_sat, o_err}), 32'd0);
        sb.delete();
        repeat (2) step();
        #2 rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_no_row", 32'(o_valid), 32'd0);
        end

        // one more row after recovery
        step(); apply(5, 1'b1);
        step(); apply(0, 1'b0);
        repeat (4) step();
        chk("final_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
